// File: rtl/pi_cmd_queue.sv
// pi_cmd_queue: Pi-side register front end for the 68k bus-cycle engine.
// Assembles bus commands from Pi register writes, queues them in a small
// FIFO with a registered head, and collects read data / BERR status for
// the Pi to read back.
module pi_cmd_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 3
) (
    input  logic        PI_CLK,
    input  logic        RESET_n,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    output logic        PI_BUSY,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [23:0] cmd_addr,
    output logic [15:0] cmd_data,
    output logic [2:0]  cmd_fc,
    output logic        cmd_rw,
    output logic        cmd_uds_n,
    output logic        cmd_lds_n,
    input  logic        rsp_valid,
    input  logic        rsp_rw,
    input  logic        rsp_berr,
    input  logic [15:0] rsp_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Popped reads awaiting completion; wide enough that it never wraps in practice.
    localparam int unsigned OUT_W = 8;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [2:0]  fc;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } cmd_t;

    // Strobe synchronisers
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic                   w_wr_rise;
    logic                   w_rd_fall;

    // Pi-visible holding registers and sticky flags
    logic [15:0] r_addr_lo;
    logic [15:0] r_data_hold;
    logic [15:0] r_rd_data;
    logic        r_overflow;
    logic        r_berr_seen;
    logic        r_armed;
    logic        r_busy;

    // FIFO storage and control
    cmd_t             r_mem [DEPTH];
    cmd_t             r_head;
    logic             r_cmd_valid;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    cmd_t             w_new_cmd;
    cmd_t             w_head_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic             w_ovf_set;

    // Read-pending tracking
    logic [CNT_W-1:0] r_rd_queued;
    logic [CNT_W-1:0] w_rd_queued_nxt;
    logic [OUT_W-1:0] r_rd_outst;
    logic [OUT_W-1:0] w_rd_outst_nxt;
    logic             w_push_rd;
    logic             w_pop_rd;
    logic             w_rsp_rd;
    logic             w_busy_nxt;

    logic             w_berr_set;
    logic             w_flag_clr;
    logic [15:0]      w_status;

    // Bring the asynchronous Pi strobes into the PI_CLK domain
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_wr_sync <= '0;
            r_rd_sync <= '0;
        end else begin
            r_wr_sync <= {r_wr_sync[SYNC_STAGES-2:0], PI_WR};
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], PI_RD};
        end
    end

    assign w_wr_rise = !r_wr_sync[SYNC_STAGES-1] &&  r_wr_sync[SYNC_STAGES-2];
    assign w_rd_fall =  r_rd_sync[SYNC_STAGES-1] && !r_rd_sync[SYNC_STAGES-2];

    // Assemble the command described by an ADDR_HI write
    always_comb begin
        w_new_cmd       = '0;
        w_new_cmd.addr  = {PI_D_IN[7:0], r_addr_lo};
        w_new_cmd.data  = r_data_hold;
        w_new_cmd.fc    = PI_D_IN[15:13];
        w_new_cmd.rw    = PI_D_IN[9];
        if (PI_D_IN[8]) begin
            w_new_cmd.uds_n = r_addr_lo[0];
            w_new_cmd.lds_n = !r_addr_lo[0];
        end else begin
            w_new_cmd.uds_n = 1'b0;
            w_new_cmd.lds_n = 1'b0;
        end
    end

    assign w_push    = w_wr_rise && (PI_A == REG_ADDR_HI);
    assign w_pop     = r_cmd_valid && cmd_ready;
    assign w_full    = (r_count == CNT_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full-FIFO push still lands
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;

    // FIFO next-state: pointers, occupancy and the next registered head entry
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_wr_ptr_nxt = r_wr_ptr;
        w_count_nxt  = r_count;
        w_head_nxt   = r_mem[r_rd_ptr];
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
        if (w_push_ok) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
        // The entry being written this cycle becomes head when it lands on the next read slot
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_new_cmd;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // FIFO state and registered head outputs
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head      <= '0;
            r_cmd_valid <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= w_new_cmd;
            end
            r_head      <= w_head_nxt;
            r_cmd_valid <= (w_count_nxt != '0);
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
        end
    end

    assign w_push_rd = w_push_ok && w_new_cmd.rw;
    assign w_pop_rd  = w_pop && r_head.rw;
    // Read responses with nothing outstanding are strays and are dropped
    assign w_rsp_rd  = rsp_valid && rsp_rw && (r_rd_outst != '0);

    // Pending reads: queued reads plus popped reads still awaiting a response
    always_comb begin
        w_rd_queued_nxt = r_rd_queued + CNT_W'(w_push_rd) - CNT_W'(w_pop_rd);
        w_rd_outst_nxt  = r_rd_outst + OUT_W'(w_pop_rd) - OUT_W'(w_rsp_rd);
        w_busy_nxt      = (w_rd_queued_nxt != '0) || (w_rd_outst_nxt != '0);
    end

    // Read-pending counters and the registered busy flag
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_rd_queued <= '0;
            r_rd_outst  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rd_queued <= w_rd_queued_nxt;
            r_rd_outst  <= w_rd_outst_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Responses are only meaningful once a command has left the FIFO since reset
    assign w_berr_set = rsp_valid && rsp_berr && r_armed;
    assign w_flag_clr = w_rd_fall && (PI_A == REG_STATUS);

    // Pi holding registers, read-back data and sticky status flags
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_addr_lo   <= '0;
            r_data_hold <= '0;
            r_rd_data   <= '0;
            r_overflow  <= 1'b0;
            r_berr_seen <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            if (w_wr_rise && (PI_A == REG_DATA)) begin
                r_data_hold <= PI_D_IN;
            end
            if (w_wr_rise && (PI_A == REG_ADDR_LO)) begin
                r_addr_lo <= PI_D_IN;
            end
            if (w_rsp_rd) begin
                r_rd_data <= rsp_data;
            end
            if (w_pop) begin
                r_armed <= 1'b1;
            end
            // A flag raised in the clear cycle takes priority over the clear
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_flag_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_berr_set) begin
                r_berr_seen <= 1'b1;
            end else if (w_flag_clr) begin
                r_berr_seen <= 1'b0;
            end
        end
    end

    // STATUS word layout: busy, overflow, berr, occupancy
    always_comb begin
        w_status                = '0;
        w_status[15]            = r_busy;
        w_status[14]            = r_overflow;
        w_status[13]            = r_berr_seen;
        w_status[12 -: CNT_W]   = r_count;
    end

    // Combinational Pi read-back mux
    always_comb begin
        PI_D_OE  = PI_RD && ((PI_A == REG_DATA) || (PI_A == REG_STATUS));
        PI_D_OUT = '0;
        case (PI_A)
            REG_DATA:   PI_D_OUT = r_rd_data;
            REG_STATUS: PI_D_OUT = w_status;
            default:    PI_D_OUT = '0;
        endcase
    end

    assign PI_BUSY   = r_busy;
    assign cmd_valid = r_cmd_valid;
    assign cmd_addr  = r_head.addr;
    assign cmd_data  = r_head.data;
    assign cmd_fc    = r_head.fc;
    assign cmd_rw    = r_head.rw;
    assign cmd_uds_n = r_head.uds_n;
    assign cmd_lds_n = r_head.lds_n;

endmodule

// File: tb/tb_pi_cmd_queue.sv
// Testbench for pi_cmd_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_pi_cmd_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] data;
        logic [2:0]  fc;
        logic        rw;
        logic        uds_n;
        logic        lds_n;
    } ent_t;

    logic        PI_CLK    = 1'b0;
    logic        RESET_n   = 1'b0;
    logic [1:0]  PI_A      = 2'd0;
    logic        PI_RD     = 1'b0;
    logic        PI_WR     = 1'b0;
    logic [15:0] PI_D_IN   = 16'h0;
    logic [15:0] PI_D_OUT;
    logic        PI_D_OE;
    logic        PI_BUSY;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [23:0] cmd_addr;
    logic [15:0] cmd_data;
    logic [2:0]  cmd_fc;
    logic        cmd_rw;
    logic        cmd_uds_n;
    logic        cmd_lds_n;
    logic        rsp_valid = 1'b0;
    logic        rsp_rw    = 1'b0;
    logic        rsp_berr  = 1'b0;
    logic [15:0] rsp_data  = 16'h0;

    int total = 0;
    int bad   = 0;

    pi_cmd_queue #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .PI_CLK(PI_CLK), .RESET_n(RESET_n), .PI_A(PI_A), .PI_RD(PI_RD), .PI_WR(PI_WR),
        .PI_D_IN(PI_D_IN), .PI_D_OUT(PI_D_OUT), .PI_D_OE(PI_D_OE), .PI_BUSY(PI_BUSY),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .cmd_fc(cmd_fc), .cmd_rw(cmd_rw), .cmd_uds_n(cmd_uds_n), .cmd_lds_n(cmd_lds_n),
        .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_berr(rsp_berr), .rsp_data(rsp_data)
    );

    always #5 PI_CLK = ~PI_CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ent_t mk_ent(input logic [15:0] lo, input logic [15:0] hold,
                                    input logic [15:0] hi);
        ent_t e;
        e.addr = {hi[7:0], lo};
        e.data = hold;
        e.fc   = hi[15:13];
        e.rw   = hi[9];
        if (hi[8]) begin
            e.uds_n = lo[0];
            e.lds_n = ~lo[0];
        end else begin
            e.uds_n = 1'b0;
            e.lds_n = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [45:0] head_now();
        return {cmd_addr, cmd_data, cmd_fc, cmd_rw, cmd_uds_n, cmd_lds_n};
    endfunction

    task automatic do_reset();
        PI_WR = 1'b0; PI_RD = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
        RESET_n = 1'b0;
        repeat (3) @(posedge PI_CLK);
        #2 RESET_n = 1'b1;
        @(posedge PI_CLK); #1;
    endtask

    // Raise PI_WR; returns one cycle before the register action lands
    task automatic pi_write_begin(input logic [1:0] a, input logic [15:0] d);
        @(posedge PI_CLK); #1;
        PI_A = a; PI_D_IN = d; PI_WR = 1'b1;
        repeat (SYNC - 1) @(posedge PI_CLK);
        #1;
    endtask

    task automatic pi_write_finish();
        @(posedge PI_CLK); #1;
    endtask

    task automatic pi_write_release();
        @(posedge PI_CLK); #1;
        PI_WR = 1'b0;
        repeat (SYNC + 1) @(posedge PI_CLK);
        #1;
    endtask

    task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
        pi_write_begin(a, d);
        pi_write_finish();
        pi_write_release();
    endtask

    task automatic pi_read(input logic [1:0] a, output logic [15:0] d, output logic oe);
        @(posedge PI_CLK); #1;
        PI_A = a; PI_RD = 1'b1;
        #1;
        d  = PI_D_OUT;
        oe = PI_D_OE;
        repeat (SYNC + 1) @(posedge PI_CLK);
        #1 PI_RD = 1'b0;
        repeat (SYNC + 1) @(posedge PI_CLK);
        #1;
    endtask

    task automatic pop_one();
        @(posedge PI_CLK); #1 cmd_ready = 1'b1;
        @(posedge PI_CLK); #1 cmd_ready = 1'b0;
    endtask

    task automatic respond(input logic rw, input logic berr, input logic [15:0] d);
        @(posedge PI_CLK); #1;
        rsp_valid = 1'b1; rsp_rw = rw; rsp_berr = berr; rsp_data = d;
        @(posedge PI_CLK); #1 rsp_valid = 1'b0; rsp_berr = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic        oe;
        do_reset();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
        total++; if (PI_BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", PI_BUSY); end
        total++; if (PI_D_OE !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", PI_D_OE); end
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h0000 || oe !== 1'b1) begin bad++; $display("FAIL reset_status: got %h oe %b want 0000 oe 1", d, oe); end
        pi_read(2'd0, d, oe);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_rd_data: got %h want 0000", d); end
        pi_read(2'd1, d, oe);
        total++; if (d !== 16'h0000 || oe !== 1'b0) begin bad++; $display("FAIL read_addr_lo: got %h oe %b want 0000 oe 0", d, oe); end
    endtask

    task automatic test_word_write();
        ent_t exp;
        pi_write(2'd0, 16'hBEEF);
        pi_write(2'd1, 16'h1234);
        pi_write_begin(2'd2, 16'h00AB);
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL word_early_valid: got %b want 0", cmd_valid); end
        pi_write_finish();
        total++; if (cmd_valid !== 1'b1) begin bad++; $display("FAIL word_valid: got %b want 1", cmd_valid); end
        pi_write_release();
        exp = '{addr: 24'hAB1234, data: 16'hBEEF, fc: 3'd0, rw: 1'b0, uds_n: 1'b0, lds_n: 1'b0};
        total++; if (head_now() !== exp) begin bad++; $display("FAIL word_head: got %h want %h", head_now(), exp); end
        total++; if (PI_BUSY !== 1'b0) begin bad++; $display("FAIL word_busy: got %b want 0", PI_BUSY); end
        pop_one();
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL word_pop_valid: got %b want 0", cmd_valid); end
    endtask

    task automatic test_byte_read();
        ent_t        exp;
        logic [15:0] d;
        logic        oe;
        pi_write(2'd1, 16'h0001);
        pi_write(2'd2, 16'hA300);
        exp = '{addr: 24'h000001, data: 16'hBEEF, fc: 3'd5, rw: 1'b1, uds_n: 1'b1, lds_n: 1'b0};
        total++; if (head_now() !== exp || cmd_valid !== 1'b1) begin bad++; $display("FAIL byte_head: got %h v%b want %h", head_now(), cmd_valid, exp); end
        total++; if (PI_BUSY !== 1'b1) begin bad++; $display("FAIL byte_busy_queued: got %b want 1", PI_BUSY); end
        pop_one();
        total++; if (PI_BUSY !== 1'b1 || cmd_valid !== 1'b0) begin bad++; $display("FAIL byte_busy_outst: got busy %b valid %b want 1 0", PI_BUSY, cmd_valid); end
        @(posedge PI_CLK); #1;
        rsp_valid = 1'b1; rsp_rw = 1'b1; rsp_berr = 1'b0; rsp_data = 16'h00C3;
        total++; if (PI_BUSY !== 1'b1) begin bad++; $display("FAIL byte_busy_rsp_cycle: got %b want 1", PI_BUSY); end
        @(posedge PI_CLK); #1 rsp_valid = 1'b0;
        total++; if (PI_BUSY !== 1'b0) begin bad++; $display("FAIL byte_busy_fall: got %b want 0", PI_BUSY); end
        pi_read(2'd0, d, oe);
        total++; if (d !== 16'h00C3 || oe !== 1'b1) begin bad++; $display("FAIL byte_rd_data: got %h oe %b want 00c3 oe 1", d, oe); end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic        oe;
        logic [23:0] exp_addr;
        for (int i = 0; i < 5; i++) begin
            pi_write(2'd1, 16'h1000 + 16'(i));
            pi_write(2'd2, 16'h0010 + 16'(i));
        end
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h5000) begin bad++; $display("FAIL ovf_status: got %h want 5000", d); end
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h1000) begin bad++; $display("FAIL ovf_cleared: got %h want 1000", d); end
        for (int i = 0; i < 4; i++) begin
            exp_addr = {8'h10 + 8'(i), 16'h1000 + 16'(i)};
            total++; if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr) begin bad++; $display("FAIL ovf_order%0d: got %h v%b want %h", i, cmd_addr, cmd_valid, exp_addr); end
            pop_one();
        end
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %b want 0", cmd_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [15:0] d;
        logic        oe;
        logic [23:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            pi_write(2'd1, 16'h2000 + 16'(i));
            pi_write(2'd2, 16'h0020 + 16'(i));
        end
        pi_write(2'd1, 16'h2004);
        pi_write_begin(2'd2, 16'h0024);
        cmd_ready = 1'b1;
        pi_write_finish();
        cmd_ready = 1'b0;
        pi_write_release();
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h1000) begin bad++; $display("FAIL fpp_status: got %h want 1000", d); end
        for (int i = 1; i < 5; i++) begin
            exp_addr = {8'h20 + 8'(i), 16'h2000 + 16'(i)};
            total++; if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr) begin bad++; $display("FAIL fpp_order%0d: got %h v%b want %h", i, cmd_addr, cmd_valid, exp_addr); end
            pop_one();
        end
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL fpp_empty_status: got %h want 0000", d); end
    endtask

    task automatic test_berr();
        logic [15:0] d;
        logic        oe;
        respond(1'b0, 1'b1, 16'h0);
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h2000) begin bad++; $display("FAIL berr_set: got %h want 2000", d); end
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL berr_clear: got %h want 0000", d); end
        // BERR landing on the same edge as the read-triggered clear
        @(posedge PI_CLK); #1;
        PI_A = 2'd3; PI_RD = 1'b1;
        repeat (SYNC + 1) @(posedge PI_CLK);
        #1 PI_RD = 1'b0;
        repeat (SYNC - 1) @(posedge PI_CLK);
        #1;
        rsp_valid = 1'b1; rsp_rw = 1'b0; rsp_berr = 1'b1;
        @(posedge PI_CLK); #1 rsp_valid = 1'b0; rsp_berr = 1'b0;
        repeat (SYNC + 1) @(posedge PI_CLK);
        #1;
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h2000) begin bad++; $display("FAIL berr_race: got %h want 2000", d); end
    endtask

    task automatic test_async_reset();
        logic [15:0] d;
        logic        oe;
        pi_write(2'd2, 16'h0200);
        pop_one();
        for (int i = 0; i < 3; i++) pi_write(2'd2, 16'h0000);
        total++; if (cmd_valid !== 1'b1 || PI_BUSY !== 1'b1) begin bad++; $display("FAIL arst_pre: got valid %b busy %b want 1 1", cmd_valid, PI_BUSY); end
        @(posedge PI_CLK); #3;
        RESET_n = 1'b0;
        #1;
        total++; if (cmd_valid !== 1'b0 || PI_BUSY !== 1'b0) begin bad++; $display("FAIL arst_immediate: got valid %b busy %b want 0 0", cmd_valid, PI_BUSY); end
        #12 RESET_n = 1'b1;
        respond(1'b1, 1'b1, 16'h5555);
        pi_read(2'd0, d, oe);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL arst_stray_data: got %h want 0000", d); end
        pi_read(2'd3, d, oe);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL arst_stray_status: got %h want 0000", d); end
    endtask

    task automatic test_random();
        ent_t        mq[$];
        ent_t        e;
        logic [15:0] m_lo, m_hold, m_rd;
        bit          m_ovf, m_berr, m_armed;
        int          m_outst, pend;
        logic [15:0] d, exp_s;
        logic        oe;
        logic [1:0]  a;
        bit          b;
        int unsigned op;
        do_reset();
        m_lo = '0; m_hold = '0; m_rd = '0;
        m_ovf = 0; m_berr = 0; m_armed = 0; m_outst = 0;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            d  = 16'($urandom);
            case (op)
                0, 1: begin
                    a = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'd3;
                    pi_write(a, d);
                    if (a == 2'd0) m_hold = d;
                end
                2: begin
                    pi_write(2'd1, d);
                    m_lo = d;
                end
                3, 4: begin
                    pi_write(2'd2, d);
                    if (mq.size() < DEPTH) mq.push_back(mk_ent(m_lo, m_hold, d));
                    else m_ovf = 1;
                end
                5, 6: begin
                    pop_one();
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        m_armed = 1;
                        if (e.rw) m_outst++;
                    end
                end
                7: begin
                    b = 1'($urandom_range(0, 1));
                    if (m_outst > 0 && $urandom_range(0, 2) != 0) begin
                        respond(1'b1, b, d);
                        m_outst--;
                        m_rd = d;
                        if (b) m_berr = 1;
                    end else if (m_armed) begin
                        respond(1'b0, b, d);
                        if (b) m_berr = 1;
                    end
                end
                8: begin
                    pend = m_outst;
                    foreach (mq[k]) if (mq[k].rw) pend++;
                    exp_s = {(pend != 0), m_ovf, m_berr, 3'(mq.size()), 10'b0};
                    pi_read(2'd3, d, oe);
                    total++; if (d !== exp_s || oe !== 1'b1) begin bad++; $display("FAIL rnd_status@%0d: got %h oe %b want %h", n, d, oe, exp_s); end
                    m_ovf = 0; m_berr = 0;
                end
                default: begin
                    pi_read(2'd0, d, oe);
                    total++; if (d !== m_rd || oe !== 1'b1) begin bad++; $display("FAIL rnd_rd_data@%0d: got %h oe %b want %h", n, d, oe, m_rd); end
                end
            endcase
            pend = m_outst;
            foreach (mq[k]) if (mq[k].rw) pend++;
            total++;
            if (cmd_valid !== (mq.size() != 0) || PI_BUSY !== (pend != 0)) begin
                bad++;
                $display("FAIL rnd_flags@%0d: got valid %b busy %b want %b %b", n, cmd_valid, PI_BUSY, (mq.size() != 0), (pend != 0));
            end
            if (mq.size() > 0) begin
                total++;
                if (head_now() !== mq[0]) begin bad++; $display("FAIL rnd_head@%0d: got %h want %h", n, head_now(), mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read();
        test_overflow();
        test_full_push_pop();
        test_berr();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pi_cmd_queue.md
Name: pi_cmd_queue

Overview:
- Pi-side command front end that sits directly upstream of the 68k bus-cycle engine.
- Decodes Pi register writes and assembles complete bus commands (address, data, FC, RW, UDS/LDS).
- Queues the commands in a small FIFO and hands them to the bus engine over a valid/ready handshake.
- Captures read-cycle responses and bus-error status for the Pi to read back; raises a busy flag while a read is unresolved.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2
SYNC_STAGES, 2, synchroniser flops on PI_RD/PI_WR, at least 2
CNT_W, 3, width of the occupancy count; must hold DEPTH

Ports:
PI_CLK  in  1  single clock for the whole block
RESET_n  in  1  asynchronous active-low reset
PI_A  in  2  register select: 0=DATA, 1=ADDR_LO, 2=ADDR_HI, 3=STATUS
PI_RD  in  1  Pi read strobe, asynchronous, active high
PI_WR  in  1  Pi write strobe, asynchronous, active high
PI_D_IN  in  16  Pi data bus, input side
PI_D_OUT  out  16  Pi data bus, output side
PI_D_OE  out  1  Pi data bus output enable
PI_BUSY  out  1  read command queued or outstanding
cmd_valid  out  1  FIFO head valid
cmd_ready  in  1  bus engine accepts the head entry
cmd_addr  out  24  68k address
cmd_data  out  16  write data
cmd_fc  out  3  function code
cmd_rw  out  1  1=read, 0=write
cmd_uds_n  out  1  upper data strobe, active low
cmd_lds_n  out  1  lower data strobe, active low
rsp_valid  in  1  one-cycle pulse when a bus cycle completes
rsp_rw  in  1  RW of the completing cycle
rsp_berr  in  1  completing cycle ended on BERR
rsp_data  in  16  read data of the completing cycle

Behaviour:
- Reset (asynchronous, RESET_n low):
  - FIFO empty; all pointers and count = 0.
  - Holding regs addr_lo, data_hold, rd_data = 0.
  - overflow = 0, berr_seen = 0, outstanding-read count = 0.
  - Outputs: cmd_valid = 0, PI_BUSY = 0, PI_D_OE = 0.
  - A reset mid-operation discards all queued commands. Any rsp_valid arriving afterwards is ignored until a new command has been popped.
- Strobe sync: PI_RD and PI_WR each pass through SYNC_STAGES flops. wr_rise is one cycle, asserted when the last stage is 0 and the previous stage is 1; rd_fall is defined likewise.
- PI_A and PI_D_IN are sampled raw on the wr_rise cycle. The Pi holds them stable while PI_WR is high.
- Register writes (on wr_rise):
  - DATA: data_hold <= PI_D_IN.
  - ADDR_LO: addr_lo <= PI_D_IN.
  - ADDR_HI: push one entry:
    - addr = {PI_D_IN[7:0], addr_lo}
    - data = data_hold
    - rw = PI_D_IN[9]
    - fc = PI_D_IN[15:13]
    - If PI_D_IN[8]=1 (byte): uds_n = addr_lo[0], lds_n = !addr_lo[0].
    - Otherwise (word): uds_n = lds_n = 0.
  - STATUS: ignored.
- FIFO:
  - Head outputs are registered. cmd_valid = (count != 0).
  - A push into an empty FIFO shows cmd_valid = 1 on the following cycle; there is no same-cycle bypass.
  - Pop occurs when cmd_valid && cmd_ready. The next entry is presented on the following cycle.
  - Push while full with no pop in the same cycle: the entry is dropped, overflow <= 1, and count is unchanged.
  - Push while full with a pop in the same cycle: the push is accepted and count stays at DEPTH.
  - Pointers wrap modulo DEPTH.
- Busy tracking:
  - rd_pending = (number of queued read entries) + (popped reads awaiting rsp_valid).
  - PI_BUSY = (rd_pending != 0), registered. It rises the cycle after the push of a read and falls the cycle after the rsp_valid with rsp_rw = 1 that brings rd_pending to 0.
  - Write responses do not affect PI_BUSY.
  - rsp_valid with rsp_rw = 1 while no read is outstanding is ignored; rd_pending never underflows.
- Responses:
  - rsp_valid && rsp_rw: rd_data <= rsp_data.
  - rsp_valid && rsp_berr: berr_seen <= 1, for reads and writes alike.
- Pi reads (combinational):
  - PI_D_OE = PI_RD && (PI_A==0 || PI_A==3).
  - PI_A=0: PI_D_OUT = rd_data.
  - PI_A=3: PI_D_OUT = {PI_BUSY, overflow, berr_seen, count[CNT_W-1:0], zeros}, with count zero-extended or placed in bits [12:10] for CNT_W=3.
  - Any other PI_A: PI_D_OUT = 0.
- Sticky-flag clear: on rd_fall, if PI_A==3, overflow and berr_seen clear.
  - A flag set in the same cycle as the clear wins and stays 1.
- A pop, a push and a response may all occur in one cycle. count and rd_pending update from all three consistently.

Test Plan:
- Word write: DATA=0xBEEF, ADDR_LO=0x1234, ADDR_HI=0x00AB (rw=0, word) -> one entry: addr=0xAB1234, data=0xBEEF, uds_n=lds_n=0, rw=0, fc=0. cmd_valid rises the cycle after the ADDR_HI wr_rise; PI_BUSY stays 0.
- Byte read with cmd_ready=0: ADDR_LO=0x0001, ADDR_HI=0xA300 (fc=5, rw=1, byte) -> uds_n=1, lds_n=0, fc=5, PI_BUSY=1. After pop, rsp_valid with rsp_data=0x00C3 -> PI_BUSY falls the next cycle; a DATA read returns 0x00C3.
- Overflow: with cmd_ready held 0, push DEPTH+1 commands -> count=4, STATUS bit14=1, fifth command absent. Pop all 4 and check order is preserved; a STATUS read, after rd_fall, clears bit14.
- Full FIFO with simultaneous push and pop -> push accepted, count stays 4, no overflow.
- BERR: write response with rsp_berr=1 -> STATUS bit13=1 until a STATUS read. A berr arriving in the clear cycle leaves bit13=1.
- Async reset asserted with 3 entries queued and a read outstanding -> cmd_valid=0 and PI_BUSY=0 immediately. A stray rsp_valid after reset leaves rd_data=0.
